// File: rtl/msb_pkg.sv
// Shared definitions for the multi-stream buffer banked read crossbar.
// Holds the default geometry, the derived field widths and the request and
// response record types used by the crossbar top and its per-port FIFOs.
package msb_pkg;

    localparam int unsigned NPORTS_D      = 8;
    localparam int unsigned DATA_W        = 64;
    localparam int unsigned WAYS_D        = 8;
    localparam int unsigned CHANNELS_D    = 2;
    localparam int unsigned NSTRMS_D      = 32;
    localparam int unsigned L1_NCL_D      = 16;
    localparam int unsigned RD_LAT_D      = 2;
    localparam int unsigned OFIFO_DEPTH_D = 4;

    localparam int unsigned CH_W   = $clog2(CHANNELS_D);
    localparam int unsigned ST_W   = $clog2(NSTRMS_D / CHANNELS_D);
    localparam int unsigned CL_W   = $clog2(L1_NCL_D);
    localparam int unsigned OF_W   = $clog2(WAYS_D);
    localparam int unsigned ADDR_W = CH_W + ST_W + CL_W;
    localparam int unsigned TAG_W  = CH_W + ST_W;
    localparam int unsigned WA_W   = ST_W + CL_W;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [ST_W-1:0] st;
        logic [CL_W-1:0] cl;
        logic [OF_W-1:0] of;
    } rd_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } rd_rsp_t;

endpackage

// File: rtl/msb_port_ofifo.sv
// Per-port show-ahead output FIFO with its admission credit counter.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   accept     a read was accepted for this port this cycle (consumes a credit)
//   push       pipeline delivers a response into the FIFO
//   push_rsp   response being delivered
//   pop_rdy    consumer ready; a pop happens on out_v & pop_rdy
//   out_v      FIFO not empty
//   out_rsp    head entry (show-ahead)
//   credit_ok  at least one credit left, port may be granted
module msb_port_ofifo
    import msb_pkg::*;
#(
    parameter int unsigned DEPTH = OFIFO_DEPTH_D
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    accept,
    input  logic    push,
    input  rd_rsp_t push_rsp,
    input  logic    pop_rdy,
    output logic    out_v,
    output rd_rsp_t out_rsp,
    output logic    credit_ok
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rd_rsp_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] credit;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_v     = (count != '0);
    assign credit_ok = (credit != '0);
    assign pop       = out_v & pop_rdy;
    assign out_rsp   = mem[rd_ptr];

    // Storage, pointers and occupancy; entries cleared so outputs read 0 in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_rsp;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Credits cover both FIFO entries and reads still in the pipeline,
    // so a granted read always finds a free slot when it lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= CNT_W'(DEPTH);
        end else begin
            case ({accept, pop})
                2'b10:   credit <= credit - CNT_W'(1);
                2'b01:   credit <= credit + CNT_W'(1);
                default: credit <= credit;
            endcase
        end
    end

endmodule

// File: rtl/msb_banked_read_xbar.sv
// Shared L1 line store: WAYS offset-interleaved banks crossbarred to NPORTS
// read ports, with per-bank round-robin arbitration, a fixed RD_LAT read
// pipeline and credit-guarded per-port output FIFOs.
// Ports:
//   clk1x, reset            clock, asynchronous active-high reset
//   i_v/i_r                 per-port read request valid / grant
//   i_ra_ch/st/cl/of        per-port read address; of selects the bank
//   o_v/o_r/o_rd/o_ra       per-port response valid / ready / data / {ch,st} tag
//   i_we/i_wa/i_wd          per-channel full-line write; way k goes to bank k
module msb_banked_read_xbar
    import msb_pkg::*;
#(
    parameter int unsigned NPORTS      = NPORTS_D,
    parameter int unsigned DATA_WIDTH  = DATA_W,
    parameter int unsigned WAYS        = WAYS_D,
    parameter int unsigned CHANNELS    = CHANNELS_D,
    parameter int unsigned NSTRMS      = NSTRMS_D,
    parameter int unsigned L1_NCL      = L1_NCL_D,
    parameter int unsigned RD_LAT      = RD_LAT_D,
    parameter int unsigned OFIFO_DEPTH = OFIFO_DEPTH_D
) (
    input  logic                                 clk1x,
    input  logic                                 reset,
    input  logic [NPORTS-1:0]                    i_v,
    output logic [NPORTS-1:0]                    i_r,
    input  logic [NPORTS*CH_W-1:0]               i_ra_ch,
    input  logic [NPORTS*ST_W-1:0]               i_ra_st,
    input  logic [NPORTS*CL_W-1:0]               i_ra_cl,
    input  logic [NPORTS*OF_W-1:0]               i_ra_of,
    output logic [NPORTS-1:0]                    o_v,
    input  logic [NPORTS-1:0]                    o_r,
    output logic [NPORTS*DATA_WIDTH-1:0]         o_rd,
    output logic [NPORTS*TAG_W-1:0]              o_ra,
    input  logic [CHANNELS-1:0]                  i_we,
    input  logic [CHANNELS*WA_W-1:0]             i_wa,
    input  logic [CHANNELS*WAYS*DATA_WIDTH-1:0]  i_wd
);

    localparam int unsigned PW    = $clog2(NPORTS);
    localparam int unsigned DEPTH = CHANNELS * (NSTRMS / CHANNELS) * L1_NCL;

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
        $error("msb_banked_read_xbar: RD_LAT must be 1..3");
    end
    if (OFIFO_DEPTH < RD_LAT + 1) begin : g_bad_depth
        $error("msb_banked_read_xbar: OFIFO_DEPTH must be at least RD_LAT+1");
    end
    if (DATA_WIDTH != DATA_W || $clog2(CHANNELS) != CH_W || $clog2(NSTRMS / CHANNELS) != ST_W ||
        $clog2(L1_NCL) != CL_W || $clog2(WAYS) != OF_W) begin : g_bad_geom
        $error("msb_banked_read_xbar: geometry differs from msb_pkg field widths");
    end

    logic [DATA_WIDTH-1:0] bank_mem [WAYS][DEPTH];
    rd_req_t               req      [NPORTS];
    rd_rsp_t               s0_rsp   [NPORTS];
    rd_rsp_t               push_rsp [NPORTS];
    rd_rsp_t               out_rsp  [NPORTS];
    logic [PW-1:0]         rr_ptr   [WAYS];
    logic [PW-1:0]         win      [WAYS];
    logic [WAYS-1:0]       win_v;
    logic [NPORTS-1:0]     credit_ok;
    logic [NPORTS-1:0]     grant;
    logic [NPORTS-1:0]     accept;
    logic [NPORTS-1:0]     push_v;

    // Unpack flat request fields and read the addressed bank (read-first vs. same-cycle write)
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            req[p].ch        = i_ra_ch[p*CH_W +: CH_W];
            req[p].st        = i_ra_st[p*ST_W +: ST_W];
            req[p].cl        = i_ra_cl[p*CL_W +: CL_W];
            req[p].of        = i_ra_of[p*OF_W +: OF_W];
            s0_rsp[p].data   = bank_mem[req[p].of][{req[p].ch, req[p].st, req[p].cl}];
            s0_rsp[p].tag    = {req[p].ch, req[p].st};
        end
    end

    // Per-bank round-robin search starting at the bank pointer; first eligible port wins
    always_comb begin
        int unsigned idx;
        logic        hit;
        idx   = 0;
        hit   = 1'b0;
        win_v = '0;
        grant = '0;
        for (int b = 0; b < WAYS; b++) begin
            win[b] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                idx      = (int'(rr_ptr[b]) + i) % NPORTS;
                hit      = !win_v[b] && i_v[idx] && credit_ok[idx] && (req[idx].of == OF_W'(b));
                win[b]   = hit ? PW'(idx) : win[b];
                win_v[b] = win_v[b] | hit;
            end
            grant[win[b]] = grant[win[b]] | win_v[b];
        end
        i_r    = grant & {NPORTS{~reset}};
        accept = i_v & i_r;
    end

    // Line writes: each channel owns its own region, so channels never collide
    always_ff @(posedge clk1x) begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < WAYS; k++) begin
                if (i_we[c]) begin
                    bank_mem[k][{CH_W'(c), i_wa[c*WA_W +: WA_W]}] <= i_wd[(c*WAYS + k)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Round-robin pointers move past the winner; idle banks keep theirs
    always_ff @(posedge clk1x or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < WAYS; b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < WAYS; b++) begin
                if (win_v[b]) begin
                    rr_ptr[b] <= (win[b] == PW'(NPORTS - 1)) ? '0 : win[b] + PW'(1);
                end
            end
        end
    end

    // The FIFO write edge provides the last cycle of latency, so RD_LAT-1 stages sit in between
    if (RD_LAT == 1) begin : g_lat1
        assign push_v   = accept;
        assign push_rsp = s0_rsp;
    end else begin : g_latn
        localparam int unsigned NSTG = RD_LAT - 1;
        logic [NPORTS-1:0] stg_v   [NSTG];
        rd_rsp_t           stg_rsp [NSTG][NPORTS];

        // Stage valids; reset discards reads in flight
        always_ff @(posedge clk1x or posedge reset) begin
            if (reset) begin
                for (int s = 0; s < NSTG; s++) begin
                    stg_v[s] <= '0;
                end
            end else begin
                stg_v[0] <= accept;
                for (int s = 1; s < NSTG; s++) begin
                    stg_v[s] <= stg_v[s-1];
                end
            end
        end

        // Stage payloads travel alongside their valids
        always_ff @(posedge clk1x) begin
            stg_rsp[0] <= s0_rsp;
            for (int s = 1; s < NSTG; s++) begin
                stg_rsp[s] <= stg_rsp[s-1];
            end
        end

        assign push_v   = stg_v[NSTG-1];
        assign push_rsp = stg_rsp[NSTG-1];
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        msb_port_ofifo #(
            .DEPTH (OFIFO_DEPTH)
        ) u_ofifo (
            .clk       (clk1x),
            .rst       (reset),
            .accept    (accept[p]),
            .push      (push_v[p]),
            .push_rsp  (push_rsp[p]),
            .pop_rdy   (o_r[p]),
            .out_v     (o_v[p]),
            .out_rsp   (out_rsp[p]),
            .credit_ok (credit_ok[p])
        );
        assign o_rd[p*DATA_WIDTH +: DATA_WIDTH] = out_rsp[p].data;
        assign o_ra[p*TAG_W +: TAG_W]           = out_rsp[p].tag;
    end

endmodule

// File: tb/tb_msb_banked_read_xbar.sv
// Directed bench for msb_banked_read_xbar: a table of single-port reads
// with hand-computed data/tags, plus sequences for arbitration, credit
// back-pressure, read-first collision and reset with reads in flight.
module tb_msb_banked_read_xbar;

    logic         clk1x;
    logic         reset;
    logic [7:0]   i_v;
    logic [7:0]   i_r;
    logic [7:0]   i_ra_ch;
    logic [31:0]  i_ra_st;
    logic [31:0]  i_ra_cl;
    logic [23:0]  i_ra_of;
    logic [7:0]   o_v;
    logic [7:0]   o_r;
    logic [511:0] o_rd;
    logic [39:0]  o_ra;
    logic [1:0]   i_we;
    logic [15:0]  i_wa;
    logic [1023:0] i_wd;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          port;
        logic        ch;
        logic [3:0]  st;
        logic [3:0]  cl;
        logic [2:0]  of;
        logic [63:0] data;
    } vec_t;

    vec_t tbl [8];

    msb_banked_read_xbar dut (
        .clk1x   (clk1x),
        .reset   (reset),
        .i_v     (i_v),
        .i_r     (i_r),
        .i_ra_ch (i_ra_ch),
        .i_ra_st (i_ra_st),
        .i_ra_cl (i_ra_cl),
        .i_ra_of (i_ra_of),
        .o_v     (o_v),
        .o_r     (o_r),
        .o_rd    (o_rd),
        .o_ra    (o_ra),
        .i_we    (i_we),
        .i_wa    (i_wa),
        .i_wd    (i_wd)
    );

    initial clk1x = 1'b0;
    always #5 clk1x = ~clk1x;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1x);
        #1;
    endtask

    task automatic set_req(input int p, input logic c, input logic [3:0] s, input logic [3:0] l, input logic [2:0] f);
        i_v[p]            = 1'b1;
        i_ra_ch[p]        = c;
        i_ra_st[p*4 +: 4] = s;
        i_ra_cl[p*4 +: 4] = l;
        i_ra_of[p*3 +: 3] = f;
    endtask

    task automatic set_wr(input int c, input logic [3:0] s, input logic [3:0] l, input logic [63:0] base);
        i_we[c]         = 1'b1;
        i_wa[c*8 +: 8]  = {s, l};
        for (int k = 0; k < 8; k++) begin
            i_wd[(c*8 + k)*64 +: 64] = base + 64'(k);
        end
    endtask

    initial begin
        logic        q_ch [4];
        logic [3:0]  q_st [4];
        logic [3:0]  q_cl [4];
        logic [63:0] q_d  [4];

        tbl[0] = '{port: 0, ch: 1'b1, st: 4'd3,  cl: 4'd5,  of: 3'd7, data: 64'h1007};
        tbl[1] = '{port: 1, ch: 1'b0, st: 4'd3,  cl: 4'd5,  of: 3'd0, data: 64'h2000};
        tbl[2] = '{port: 7, ch: 1'b0, st: 4'd15, cl: 4'd15, of: 3'd4, data: 64'h3004};
        tbl[3] = '{port: 4, ch: 1'b1, st: 4'd0,  cl: 4'd0,  of: 3'd6, data: 64'h4006};
        tbl[4] = '{port: 2, ch: 1'b1, st: 4'd3,  cl: 4'd5,  of: 3'd1, data: 64'h1001};
        tbl[5] = '{port: 6, ch: 1'b0, st: 4'd15, cl: 4'd15, of: 3'd7, data: 64'h3007};
        tbl[6] = '{port: 3, ch: 1'b0, st: 4'd3,  cl: 4'd5,  of: 3'd3, data: 64'h2003};
        tbl[7] = '{port: 5, ch: 1'b1, st: 4'd0,  cl: 4'd0,  of: 3'd0, data: 64'h4000};

        q_ch = '{1'b1, 1'b0, 1'b0, 1'b1};
        q_st = '{4'd3, 4'd3, 4'd15, 4'd0};
        q_cl = '{4'd5, 4'd5, 4'd15, 4'd0};
        q_d  = '{64'h1003, 64'h2003, 64'h3003, 64'h4003};

        reset = 1'b0; i_v = '0; i_ra_ch = '0; i_ra_st = '0; i_ra_cl = '0; i_ra_of = '0;
        o_r = 8'hFF; i_we = '0; i_wa = '0; i_wd = '0;

        // Reset state: grants blocked and outputs quiet even with requests pending
        #1 reset = 1'b1;
        i_v = 8'hFF;
        #1;
        chk("rst_i_r", 64'(i_r), 64'h0);
        chk("rst_o_v", 64'(o_v), 64'h0);
        chk("rst_o_rd_zero", 64'(|o_rd), 64'h0);
        chk("rst_o_ra_zero", 64'(|o_ra), 64'h0);
        step(); step();
        i_v = '0; reset = 1'b0;
        step();

        // Round-robin on bank 4: 0, 2, 5 in turn, then 6 beats 0
        set_req(0, 1'b0, 4'd0, 4'd0, 3'd4);
        set_req(2, 1'b0, 4'd0, 4'd0, 3'd4);
        set_req(5, 1'b0, 4'd0, 4'd0, 3'd4);
        #1; chk("rr_first", 64'(i_r), 64'h01);
        step(); i_v[0] = 1'b0;
        #1; chk("rr_second", 64'(i_r), 64'h04);
        step(); i_v[2] = 1'b0;
        #1; chk("rr_third", 64'(i_r), 64'h20);
        step(); i_v[5] = 1'b0;
        set_req(0, 1'b0, 4'd0, 4'd0, 3'd4);
        set_req(6, 1'b0, 4'd0, 4'd0, 3'd4);
        #1; chk("rr_ptr6_wins", 64'(i_r), 64'h40);
        step(); i_v = '0;
        step(); step(); step();

        // Lines A (ch1) and B (ch0) share {st,cl}; then C and D
        set_wr(1, 4'd3, 4'd5, 64'h1000);
        set_wr(0, 4'd3, 4'd5, 64'h2000);
        step(); i_we = '0;
        set_wr(0, 4'd15, 4'd15, 64'h3000);
        set_wr(1, 4'd0, 4'd0, 64'h4000);
        step(); i_we = '0;

        // Table: single reads, latency exactly two cycles
        for (int v = 0; v < 8; v++) begin
            set_req(tbl[v].port, tbl[v].ch, tbl[v].st, tbl[v].cl, tbl[v].of);
            #1; chk($sformatf("tbl%0d_i_r", v), 64'(i_r[tbl[v].port]), 64'h1);
            step(); i_v = '0;
            chk($sformatf("tbl%0d_o_v_early", v), 64'(o_v), 64'h0);
            step();
            chk($sformatf("tbl%0d_o_v", v), 64'(o_v), 64'(8'h01 << tbl[v].port));
            chk($sformatf("tbl%0d_o_rd", v), o_rd[tbl[v].port*64 +: 64], tbl[v].data);
            chk($sformatf("tbl%0d_o_ra", v), 64'(o_ra[tbl[v].port*5 +: 5]), 64'({tbl[v].ch, tbl[v].st}));
        end
        step();

        // All ports, distinct banks, same cycle
        for (int p = 0; p < 8; p++) set_req(p, 1'b1, 4'd3, 4'd5, 3'(p));
        #1; chk("all_i_r", 64'(i_r), 64'hFF);
        step(); i_v = '0;
        chk("all_o_v_early", 64'(o_v), 64'h0);
        step();
        chk("all_o_v", 64'(o_v), 64'hFF);
        for (int p = 0; p < 8; p++) begin
            chk($sformatf("all_o_rd%0d", p), o_rd[p*64 +: 64], 64'h1000 + 64'(p));
            chk($sformatf("all_o_ra%0d", p), 64'(o_ra[p*5 +: 5]), 64'h13);
        end
        step();

        // Credit back-pressure on port 3: four accepts then blocked
        o_r[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(3, q_ch[k], q_st[k], q_cl[k], 3'd3);
            #1; chk($sformatf("cred_acc%0d", k), 64'(i_r[3]), 64'h1);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            set_req(3, 1'b1, 4'd3, 4'd5, 3'd3);
            #1; chk($sformatf("cred_block%0d", k), 64'(i_r[3]), 64'h0);
            step();
        end
        i_v = '0;
        o_r[3] = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cred_o_v%0d", k), 64'(o_v[3]), 64'h1);
            chk($sformatf("cred_o_rd%0d", k), o_rd[3*64 +: 64], q_d[k]);
            chk($sformatf("cred_o_ra%0d", k), 64'(o_ra[3*5 +: 5]), 64'({q_ch[k], q_st[k]}));
            step();
        end
        chk("cred_drained", 64'(o_v[3]), 64'h0);
        step();
        chk("cred_no_dup", 64'(o_v[3]), 64'h0);

        // Read-first: same-cycle write returns old data, next read sees new
        set_wr(1, 4'd3, 4'd5, 64'h5000);
        set_req(1, 1'b1, 4'd3, 4'd5, 3'd2);
        #1; chk("rf_i_r0", 64'(i_r[1]), 64'h1);
        step(); i_we = '0;
        #1; chk("rf_i_r1", 64'(i_r[1]), 64'h1);
        step(); i_v = '0;
        chk("rf_o_v0", 64'(o_v[1]), 64'h1);
        chk("rf_old", o_rd[1*64 +: 64], 64'h1002);
        step();
        chk("rf_o_v1", 64'(o_v[1]), 64'h1);
        chk("rf_new", o_rd[1*64 +: 64], 64'h5002);
        step();
        chk("rf_o_v_end", 64'(o_v[1]), 64'h0);

        // Reset with three reads in flight
        set_req(0, 1'b1, 4'd3, 4'd5, 3'd0);
        set_req(1, 1'b1, 4'd3, 4'd5, 3'd1);
        set_req(2, 1'b1, 4'd3, 4'd5, 3'd2);
        step(); i_v = '0;
        reset = 1'b1;
        for (int p = 0; p < 8; p++) set_req(p, 1'b1, 4'd3, 4'd5, 3'(p));
        #1;
        chk("rst2_i_r", 64'(i_r), 64'h0);
        chk("rst2_o_v", 64'(o_v), 64'h0);
        step(); step();
        reset = 1'b0; i_v = '0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst2_no_stale%0d", k), 64'(o_v), 64'h0);
            step();
        end
        set_req(0, 1'b1, 4'd3, 4'd5, 3'd0);
        set_req(7, 1'b1, 4'd3, 4'd5, 3'd0);
        #1; chk("rst2_rr_ptr0", 64'(i_r), 64'h01);
        step(); i_v = '0;
        step(); step();
        o_r[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 4'd3, 4'd5, 3'd0);
            #1; chk($sformatf("rst2_cred%0d", k), 64'(i_r[0]), 64'h1);
            step();
        end
        set_req(0, 1'b1, 4'd3, 4'd5, 3'd0);
        #1; chk("rst2_cred_block", 64'(i_r[0]), 64'h0);
        step(); i_v = '0;
        o_r[0] = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("rst2_drained", 64'(o_v), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
